// File: rtl/seq_mult_pkg.sv
// Shared types and pin-map constants for the sequential shift-add multiplier.
package seq_mult_pkg;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   localparam int START  = 0;
   localparam int SIGNED = 1;
   localparam int ACC    = 2;
   localparam int CLEAR  = 3;
   localparam int BUSY   = 7;
   localparam int DONE   = 6;

   localparam logic [7:0] UIO_OE_VAL = 8'hC0;

endpackage

// File: rtl/seq_mult_datapath.sv
// Operand latches, partial-product add/subtract and result/accumulate register.
module seq_mult_datapath
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int ACC_W = 8,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step,
   input  logic             last,
   input  logic             clr,
   input  logic [CNT_W-1:0] idx,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sgn,
   input  logic             acc,
   output logic [ACC_W-1:0] result
);

   localparam int PW = 2 * WIDTH;

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             sgn_q;
   logic             acc_q;
   logic [PW-1:0]    partial;
   logic [PW-1:0]    ext_a;
   logic [PW-1:0]    addend;
   logic [PW-1:0]    p_next;
   logic [ACC_W-1:0] prod_ext;

   // The MSB of a signed multiplier carries negative weight.
   always_comb begin
      ext_a  = {{(PW-WIDTH){sgn_q & a_q[WIDTH-1]}}, a_q};
      addend = ext_a << idx;
      p_next = partial;
      if (b_q[idx]) begin
         if (sgn_q && idx == CNT_W'(WIDTH-1))
            p_next = partial - addend;
         else
            p_next = partial + addend;
      end
   end

   always_comb begin
      prod_ext = {ACC_W{sgn_q & p_next[PW-1]}};
      prod_ext[PW-1:0] = p_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sgn_q   <= 1'b0;
         acc_q   <= 1'b0;
         partial <= '0;
         result  <= '0;
      end else begin
         if (load) begin
            a_q     <= a;
            b_q     <= b;
            sgn_q   <= sgn;
            acc_q   <= acc;
            partial <= '0;
         end else if (step) begin
            partial <= p_next;
            if (last)
               result <= acc_q ? result + prod_ext : prod_ext;
         end
         if (clr)
            result <= '0;
      end
   end

endmodule

// File: rtl/seq_mult_param.sv
// Sequential signed/unsigned multiply-accumulate on the TinyTapeout pinout.
module seq_mult_param
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int ACC_W = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int CNT_W = $clog2(WIDTH);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             busy;
   logic             done;
   logic             start_q;
   logic             start_edge;
   logic             last;
   logic             load;
   logic             step;
   logic             clr;
   logic             unused_ok;

   assign start_edge = uio_in[START] & ~start_q;
   assign last       = (cnt == CNT_W'(WIDTH-1));
   assign load = ena && state == IDLE && start_edge && !uio_in[CLEAR];
   assign clr  = ena && state == IDLE && uio_in[CLEAR];
   assign step = ena && state == RUN;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         start_q <= 1'b0;
      end else if (ena) begin
         start_q <= uio_in[START];
         unique case (state)
            IDLE: begin
               if (uio_in[CLEAR]) begin
                  done <= 1'b0;
               end else if (start_edge) begin
                  cnt   <= '0;
                  busy  <= 1'b1;
                  done  <= 1'b0;
                  state <= RUN;
               end
            end
            RUN: begin
               cnt <= cnt + 1'b1;
               if (last) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   seq_mult_datapath #(
      .WIDTH (WIDTH),
      .ACC_W (ACC_W),
      .CNT_W (CNT_W)
   ) u_dp (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load),
      .step   (step),
      .last   (last),
      .clr    (clr),
      .idx    (cnt),
      .a      (ui_in[WIDTH-1:0]),
      .b      (ui_in[WIDTH+3:4]),
      .sgn    (uio_in[SIGNED]),
      .acc    (uio_in[ACC]),
      .result (uo_out)
   );

   always_comb begin
      uio_out       = '0;
      uio_out[BUSY] = busy;
      uio_out[DONE] = done;
   end

   assign uio_oe    = UIO_OE_VAL;
   assign unused_ok = &{1'b0, ui_in, uio_in[7:4]};

endmodule

// File: tb/tb_seq_mult_param.sv
// Directed self-checking bench for seq_mult_param.
module tb_seq_mult_param;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int checks   = 0;
   int failures = 0;

   seq_mult_param #(
      .WIDTH (4),
      .ACC_W (8)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // uio_in = {4'b0, clear, acc, sgn, start}
   task automatic set_ctl(input logic clr, input logic acc,
                          input logic sgn, input logic st);
      uio_in = {4'b0, clr, acc, sgn, st};
   endtask

   // Pulses start for one cycle then runs the four iterations.
   task automatic run_op(input logic [7:0] ui, input logic sgn,
                         input logic acc);
      ui_in = ui;
      set_ctl(1'b0, acc, sgn, 1'b1);
      tick();
      set_ctl(1'b0, acc, sgn, 1'b0);
      repeat (4) tick();
   endtask

   task automatic test_reset();
      checks++;
      if (uo_out !== 8'h00) begin
         failures++;
         $display("FAIL reset_uo got=%h want=00", uo_out);
      end
      checks++;
      if (uio_out !== 8'h00) begin
         failures++;
         $display("FAIL reset_uio_out got=%h want=00", uio_out);
      end
      checks++;
      if (uio_oe !== 8'hC0) begin
         failures++;
         $display("FAIL reset_uio_oe got=%h want=c0", uio_oe);
      end
   endtask

   task automatic test_unsigned();
      ui_in = 8'hFF;
      set_ctl(1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (uio_out !== 8'h80) begin
            failures++;
            $display("FAIL unsigned_busy cyc=%0d got=%h want=80", i, uio_out);
         end
         tick();
      end
      checks++;
      if (uo_out !== 8'hE1 || uio_out !== 8'h40) begin
         failures++;
         $display("FAIL unsigned_ff got uo=%h uio=%h want uo=e1 uio=40",
                  uo_out, uio_out);
      end
   endtask

   task automatic test_signed();
      run_op(8'h88, 1'b1, 1'b0);
      checks++;
      if (uo_out !== 8'h40) begin
         failures++;
         $display("FAIL signed_m8m8 got=%h want=40", uo_out);
      end
      run_op(8'h87, 1'b1, 1'b0);
      checks++;
      if (uo_out !== 8'hC8) begin
         failures++;
         $display("FAIL signed_7m8 got=%h want=c8", uo_out);
      end
   endtask

   task automatic test_accumulate();
      set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
         failures++;
         $display("FAIL acc_clear got uo=%h uio=%h want 00 00", uo_out, uio_out);
      end
      run_op(8'h53, 1'b0, 1'b0);
      checks++;
      if (uo_out !== 8'h0F) begin
         failures++;
         $display("FAIL acc_first got=%h want=0f", uo_out);
      end
      run_op(8'h22, 1'b0, 1'b1);
      checks++;
      if (uo_out !== 8'h13) begin
         failures++;
         $display("FAIL acc_add got=%h want=13", uo_out);
      end
      set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
      run_op(8'hFF, 1'b0, 1'b0);
      run_op(8'hFF, 1'b0, 1'b1);
      checks++;
      if (uo_out !== 8'hC2) begin
         failures++;
         $display("FAIL acc_wrap got=%h want=c2", uo_out);
      end
   endtask

   task automatic test_start_held();
      int busy_cycles;
      busy_cycles = 0;
      ui_in = 8'h23;
      set_ctl(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         tick();
         if (uio_out[7]) busy_cycles++;
      end
      set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checks++;
      if (busy_cycles !== 4) begin
         failures++;
         $display("FAIL held_busy_cycles got=%0d want=4", busy_cycles);
      end
      checks++;
      if (uo_out !== 8'h06 || uio_out !== 8'h40) begin
         failures++;
         $display("FAIL held_result got uo=%h uio=%h want 06 40",
                  uo_out, uio_out);
      end
   endtask

   task automatic test_back_to_back();
      ui_in = 8'h35;
      set_ctl(1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) tick();
      ui_in = 8'hFF;
      set_ctl(1'b0, 1'b1, 1'b1, 1'b1);
      tick();
      set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checks++;
      if (uo_out !== 8'h0F || uio_out !== 8'h40) begin
         failures++;
         $display("FAIL restart_result got uo=%h uio=%h want 0f 40",
                  uo_out, uio_out);
      end
      repeat (3) tick();
      checks++;
      if (uo_out !== 8'h0F || uio_out !== 8'h40) begin
         failures++;
         $display("FAIL restart_not_queued got uo=%h uio=%h want 0f 40",
                  uo_out, uio_out);
      end
   endtask

   task automatic test_ena();
      ui_in = 8'h46;
      set_ctl(1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      ena = 1'b0;
      ui_in = 8'h00;
      repeat (3) tick();
      checks++;
      if (uio_out !== 8'h80) begin
         failures++;
         $display("FAIL ena_hold_busy got=%h want=80", uio_out);
      end
      ena = 1'b1;
      repeat (2) tick();
      checks++;
      if (uio_out !== 8'h80) begin
         failures++;
         $display("FAIL ena_stretch got=%h want=80", uio_out);
      end
      tick();
      checks++;
      if (uo_out !== 8'h18 || uio_out !== 8'h40) begin
         failures++;
         $display("FAIL ena_result got uo=%h uio=%h want 18 40",
                  uo_out, uio_out);
      end
   endtask

   task automatic test_reset_midrun();
      ui_in = 8'hFF;
      set_ctl(1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) tick();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
         failures++;
         $display("FAIL reset_midrun got uo=%h uio=%h want 00 00",
                  uo_out, uio_out);
      end
      #1 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_clear_start();
      run_op(8'h23, 1'b0, 1'b0);
      set_ctl(1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      checks++;
      if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
         failures++;
         $display("FAIL clear_start got uo=%h uio=%h want 00 00",
                  uo_out, uio_out);
      end
      set_ctl(1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      checks++;
      if (uio_out !== 8'h00) begin
         failures++;
         $display("FAIL clear_start_dropped got=%h want=00", uio_out);
      end
      set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
   endtask

   initial begin
      rst_n  = 1'b0;
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      repeat (2) tick();
      test_reset();
      #2 rst_n = 1'b1;
      tick();
      test_unsigned();
      test_signed();
      test_accumulate();
      test_start_held();
      test_back_to_back();
      test_ena();
      test_reset_midrun();
      test_clear_start();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
